pipe_skid: RTL and testbench
============================

# pipe_skid

Two-entry skid-buffered pipeline register for the core's inter-stage valid/ready paths. It is the consumer-facing counterpart to the enable-gated state flops. Upstream writes with `s_valid`/`s_ready`; downstream reads with `m_valid`/`m_ready`. It sustains one transfer per cycle while registering `s_ready`, which breaks the ready combinational path between stages. It sits between fetch/decode and decode/execute stages wherever backpressure exists.

## Interface
- `WIDTH`, 32, payload bit width
- `RST_DATA`, `{WIDTH{1'b0}}`, reset value of both data registers and therefore of `m_data`
- `clk` input 1: single clock, all state on rising edge
- `rstn` input 1: reset, asynchronous, active-low
- `s_valid` input 1: upstream presents `s_data`
- `s_ready` output 1: block accepts this cycle; driven directly from a flop
- `s_data` input WIDTH: upstream payload
- `m_valid` output 1: `m_data` holds a valid payload
- `m_ready` input 1: downstream consumes this cycle
- `m_data` output WIDTH: payload, driven directly from the main register
- `flush` input 1: synchronous discard; present only with `PIPE_SKID_FLUSH_EN`

## Operation
- Definitions:
  - accept = `s_valid & s_ready`
  - consume = `m_valid & m_ready`
- Storage: main register (drives `m_data`) and skid register. State is encoded as EMPTY, BUSY or FULL.
- EMPTY (`m_valid=0`, `s_ready=1`):
  - accept: main <= `s_data` -> BUSY.
  - `m_ready` is ignored.
- BUSY (`m_valid=1`, `s_ready=1`):
  - accept & consume: main <= `s_data`, stay BUSY.
  - accept & !consume: skid <= `s_data`, `s_ready`<=0 -> FULL.
  - !accept & consume: -> EMPTY.
  - neither: hold.
- FULL (`m_valid=1`, `s_ready=0`):
  - consume: main <= skid, `s_ready`<=1 -> BUSY.
  - else hold.
  - `s_valid` is ignored because `s_ready` is 0.
- No payload is ever dropped or duplicated. Order is strict FIFO.
- `m_data` is stable whenever `m_valid & !m_ready`.
- The skid register is written only on the BUSY accept & !consume transition.

## Timing
- Reset (async, `rstn`=0):
  - `m_valid`=0, `s_ready`=1, state EMPTY.
  - main = skid = `RST_DATA`, so `m_data`=`RST_DATA`.
- Reset asserted mid-operation: all held payloads are lost immediately, and outputs take their reset values without waiting for a clock edge.
- Latency: accept in cycle N gives `m_valid`=1 with that data in cycle N+1.
- Throughput: 1 transfer/cycle in steady state with `m_ready`=1.
- `s_ready` falls the cycle after a stall begins. The skid register absorbs the one beat accepted in the stall cycle.
- `s_ready` rises the cycle after the FULL consume.
- Bubble-free: FULL consume in cycle N allows a new accept in cycle N+1.
- No outputs are combinational from inputs.

## Configuration
- Macro: `PIPE_SKID_FLUSH_EN`.
- Defined: `flush` port exists. `flush`=1 at a rising edge forces EMPTY on the next cycle, with `m_valid`=0 and `s_ready`=1. Data registers hold their contents, which are don't-care.
- Flush overrides a simultaneous accept and consume:
  - the beat accepted that cycle is discarded;
  - the beat consumed that cycle counts as delivered.
- Not defined: no `flush` port. Only reset clears state.

## Structure
- Shared defines file holds:
  - the state encodings `PIPE_SKID_EMPTY`=2'b00, `PIPE_SKID_BUSY`=2'b01, `PIPE_SKID_FULL`=2'b10;
  - the `PIPE_SKID_FLUSH_EN` default.
- Sub-module `skid_slot`: a WIDTH-bit enable register with parameterised reset value. It is instantiated twice, once for main and once for skid. Control flops live in `pipe_skid`.

## Test plan
- Reset: hold `rstn`=0 with `s_valid`=1 and `s_data`=32'hDEAD_BEEF -> `m_valid`=0, `s_ready`=1, `m_data`=`RST_DATA`; no capture.
- Streaming: send 8 beats 1..8 back-to-back with `m_ready`=1 -> `m_data` shows 1..8 on consecutive cycles, one cycle after each accept; `s_ready` stays 1.
- Stall absorb:
  - Stimulus: beats A=0x11 and B=0x22 accepted on consecutive cycles, with `m_ready`=0 from the cycle B is accepted.
  - Response: FULL; `s_ready`=0 the next cycle; `m_data`=0x11 held.
  - Then raise `m_ready`: 0x11, then 0x22 delivered; `s_ready` returns to 1 after one cycle.
- Random valid/ready: 10k cycles with 50% `s_valid` and 50% `m_ready` -> the scoreboard sees an exact in-order match and no payload change while stalled.
- Flush (macro defined): in FULL, assert `flush` with `s_valid`=1 -> next cycle `m_valid`=0, `s_ready`=1; neither held beat nor the offered beat is ever output.
- Async reset mid-FULL: drop `rstn` between edges -> `m_valid`=0 and `s_ready`=1 immediately; the first beat after release is delivered correctly.

Source files
------------

// File: rtl/pipe_skid_pkg.sv
// Shared encodings for the pipe_skid valid/ready skid buffer.
// PIPE_SKID_FLUSH_EN is left undefined by default, so the default build has no flush port.
package pipe_skid_pkg;

  typedef enum logic [1:0] {
    PIPE_SKID_EMPTY = 2'b00,
    PIPE_SKID_BUSY  = 2'b01,
    PIPE_SKID_FULL  = 2'b10
  } pipe_skid_state_e;

endpackage : pipe_skid_pkg

// File: rtl/skid_slot.sv
// WIDTH-bit enable register with a parameterised reset value.
// pipe_skid uses one instance for the main payload and one for the skid payload.
module skid_slot #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RST_DATA = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: payload registers get a defined reset value so m_data is known straight out of reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= RST_DATA;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : skid_slot

// File: rtl/pipe_skid.sv
// Two-entry skid-buffered valid/ready pipeline register with a registered s_ready.
// Define PIPE_SKID_FLUSH_EN to add the synchronous flush input.
module pipe_skid
  import pipe_skid_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RST_DATA = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
`ifdef PIPE_SKID_FLUSH_EN
  input  logic             flush,
`endif
  output logic [WIDTH-1:0] m_data
);

  pipe_skid_state_e state_q, state_d;
  logic             s_ready_q, s_ready_d;
  logic             m_valid_q, m_valid_d;
  logic             main_en, skid_en, load_from_skid;
  logic             accept, consume;
  logic [WIDTH-1:0] main_d, main_q, skid_q;

  assign accept  = s_valid & s_ready_q;
  assign consume = m_valid_q & m_ready;

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d        = state_q;
    s_ready_d      = s_ready_q;
    m_valid_d      = m_valid_q;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    load_from_skid = 1'b0;

    unique case (state_q)
      PIPE_SKID_EMPTY: begin
        if (accept) begin
          main_en   = 1'b1;
          m_valid_d = 1'b1;
          state_d   = PIPE_SKID_BUSY;
        end
      end
      PIPE_SKID_BUSY: begin
        if (accept && consume) begin
          main_en = 1'b1;
        end else if (accept) begin
          // Downstream stalled this cycle: park the beat so s_ready can drop a cycle late.
          skid_en   = 1'b1;
          s_ready_d = 1'b0;
          state_d   = PIPE_SKID_FULL;
        end else if (consume) begin
          m_valid_d = 1'b0;
          state_d   = PIPE_SKID_EMPTY;
        end
      end
      PIPE_SKID_FULL: begin
        if (consume) begin
          main_en        = 1'b1;
          load_from_skid = 1'b1;
          s_ready_d      = 1'b1;
          state_d        = PIPE_SKID_BUSY;
        end
      end
      default: begin
        m_valid_d = 1'b0;
        s_ready_d = 1'b1;
        state_d   = PIPE_SKID_EMPTY;
      end
    endcase

`ifdef PIPE_SKID_FLUSH_EN
    // Flush wins over any accept/consume; payload contents become don't-care.
    if (flush) begin
      main_en   = 1'b0;
      skid_en   = 1'b0;
      m_valid_d = 1'b0;
      s_ready_d = 1'b1;
      state_d   = PIPE_SKID_EMPTY;
    end
`endif

    main_d = load_from_skid ? skid_q : s_data;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= PIPE_SKID_EMPTY;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
    end
  end

  skid_slot #(
    .WIDTH    (WIDTH),
    .RST_DATA (RST_DATA)
  ) u_main_slot (
    .clk  (clk),
    .rstn (rstn),
    .en   (main_en),
    .d    (main_d),
    .q    (main_q)
  );

  skid_slot #(
    .WIDTH    (WIDTH),
    .RST_DATA (RST_DATA)
  ) u_skid_slot (
    .clk  (clk),
    .rstn (rstn),
    .en   (skid_en),
    .d    (s_data),
    .q    (skid_q)
  );

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data  = main_q;

endmodule : pipe_skid

// File: tb/tb_pipe_skid.sv
// Self-checking bench for pipe_skid: directed scenarios plus random valid/ready
// traffic scored against a two-entry FIFO model of the buffer contents.
module tb_pipe_skid;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rstn;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
`ifdef PIPE_SKID_FLUSH_EN
  logic             flush;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: payloads currently held by the buffer, oldest first.
  logic [WIDTH-1:0] exp_q[$];

  pipe_skid #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
`ifdef PIPE_SKID_FLUSH_EN
    .flush   (flush),
`endif
    .m_data  (m_data)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and update the model from the handshakes seen at that edge.
  task automatic tick();
    bit acc, con, fl;
    acc = s_valid && s_ready;
    con = m_valid && m_ready;
    fl  = 1'b0;
`ifdef PIPE_SKID_FLUSH_EN
    fl  = flush;
`endif
    @(posedge clk);
    #1;
    if (con && exp_q.size() > 0) void'(exp_q.pop_front());
    if (fl) exp_q.delete();
    else if (acc) exp_q.push_back(s_data);
  endtask

  task automatic test_reset();
    rstn    = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'hDEAD_BEEF;
    m_ready = 1'b0;
`ifdef PIPE_SKID_FLUSH_EN
    flush   = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (m_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_m_valid: got %b want 0", m_valid);
    end
    tests_run++;
    if (s_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_s_ready: got %b want 1", s_ready);
    end
    tests_run++;
    if (m_data !== 32'h0) begin
      tests_failed++; $display("FAIL reset_m_data: got %h want 00000000", m_data);
    end
    s_valid = 1'b0;
    rstn    = 1'b1;
    exp_q.delete();
    tick();
    tests_run++;
    if (m_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_no_capture: m_valid got %b want 0", m_valid);
    end
  endtask

  task automatic test_stream();
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      s_valid = 1'b1;
      s_data  = i;
      tick();
      tests_run++;
      if (m_valid !== 1'b1 || m_data !== WIDTH'(i) || s_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL stream_beat%0d: got v=%b d=%h r=%b want v=1 d=%h r=1",
                 i, m_valid, m_data, s_ready, WIDTH'(i));
      end
    end
    s_valid = 1'b0;
    tick();
    tests_run++;
    if (m_valid !== 1'b0) begin
      tests_failed++; $display("FAIL stream_drain: m_valid got %b want 0", m_valid);
    end
  endtask

  task automatic test_stall();
    s_valid = 1'b1; s_data = 32'h11; m_ready = 1'b1;
    tick();
    s_data = 32'h22; m_ready = 1'b0;
    tick();
    tests_run++;
    if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== 32'h11) begin
      tests_failed++;
      $display("FAIL stall_full: got r=%b v=%b d=%h want r=0 v=1 d=00000011", s_ready, m_valid, m_data);
    end
    s_data = 32'h33;
    tick();
    tests_run++;
    if (s_ready !== 1'b0 || m_data !== 32'h11) begin
      tests_failed++;
      $display("FAIL stall_hold: got r=%b d=%h want r=0 d=00000011", s_ready, m_data);
    end
    s_valid = 1'b0; m_ready = 1'b1;
    tick();
    tests_run++;
    if (s_ready !== 1'b1 || m_valid !== 1'b1 || m_data !== 32'h22) begin
      tests_failed++;
      $display("FAIL stall_release: got r=%b v=%b d=%h want r=1 v=1 d=00000022", s_ready, m_valid, m_data);
    end
    tick();
    tests_run++;
    if (m_valid !== 1'b0) begin
      tests_failed++; $display("FAIL stall_drain: m_valid got %b want 0", m_valid);
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] prev_data;
    bit               prev_stall;
    prev_stall = 1'b0;
    prev_data  = '0;
    for (int c = 0; c < 10000; c++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data  = $urandom;
      m_ready = 1'($urandom_range(0, 1));
      #1;
      tests_run++;
      if (m_valid !== (exp_q.size() > 0)) begin
        tests_failed++;
        $display("FAIL rand_m_valid cycle %0d: got %b want %b", c, m_valid, exp_q.size() > 0);
      end
      tests_run++;
      if (s_ready !== (exp_q.size() < 2)) begin
        tests_failed++;
        $display("FAIL rand_s_ready cycle %0d: got %b want %b", c, s_ready, exp_q.size() < 2);
      end
      if (exp_q.size() > 0) begin
        tests_run++;
        if (m_data !== exp_q[0]) begin
          tests_failed++;
          $display("FAIL rand_m_data cycle %0d: got %h want %h", c, m_data, exp_q[0]);
        end
      end
      if (prev_stall) begin
        tests_run++;
        if (m_data !== prev_data) begin
          tests_failed++;
          $display("FAIL rand_stable cycle %0d: got %h want %h", c, m_data, prev_data);
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      tick();
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (3) tick();
    tests_run++;
    if (m_valid !== 1'b0 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL rand_drain: m_valid got %b, model holds %0d", m_valid, exp_q.size());
    end
  endtask

`ifdef PIPE_SKID_FLUSH_EN
  task automatic test_flush();
    s_valid = 1'b1; s_data = 32'h55; m_ready = 1'b0;
    tick();
    s_data = 32'h66;
    tick();
    flush = 1'b1; s_data = 32'h77;
    tick();
    flush = 1'b0; s_valid = 1'b0;
    tests_run++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_empty: got v=%b r=%b want v=0 r=1", m_valid, s_ready);
    end
    m_ready = 1'b1;
    repeat (2) tick();
    tests_run++;
    if (m_valid !== 1'b0) begin
      tests_failed++; $display("FAIL flush_no_output: m_valid got %b want 0", m_valid);
    end
    s_valid = 1'b1; s_data = 32'h88;
    tick();
    s_valid = 1'b0;
    tests_run++;
    if (m_valid !== 1'b1 || m_data !== 32'h88) begin
      tests_failed++;
      $display("FAIL flush_next_beat: got v=%b d=%h want v=1 d=00000088", m_valid, m_data);
    end
    tick();
  endtask
`endif

  task automatic test_async_reset();
    s_valid = 1'b1; s_data = 32'hA1; m_ready = 1'b0;
    tick();
    s_data = 32'hA2;
    tick();
    s_valid = 1'b0;
    tests_run++;
    if (s_ready !== 1'b0 || m_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL arst_setup_full: got r=%b v=%b want r=0 v=1", s_ready, m_valid);
    end
    #2;
    rstn = 1'b0;
    #1;
    exp_q.delete();
    tests_run++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || m_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL arst_immediate: got v=%b r=%b d=%h want v=0 r=1 d=00000000", m_valid, s_ready, m_data);
    end
    @(posedge clk);
    #1;
    rstn    = 1'b1;
    s_valid = 1'b1; s_data = 32'hB3; m_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    tests_run++;
    if (m_valid !== 1'b1 || m_data !== 32'hB3) begin
      tests_failed++;
      $display("FAIL arst_first_beat: got v=%b d=%h want v=1 d=000000b3", m_valid, m_data);
    end
    tick();
    tests_run++;
    if (m_valid !== 1'b0) begin
      tests_failed++; $display("FAIL arst_drain: m_valid got %b want 0", m_valid);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_random();
`ifdef PIPE_SKID_FLUSH_EN
    test_flush();
`endif
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_pipe_skid
